// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 sizes, FSM states and byte-mask bases.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane replication / byte-enable generation, load extraction and
// access-fault detection for a 32-bit data memory port.
module lsu_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_wmask,
  output logic            st_fault,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  function automatic logic [XLEN-1:0] ext8(input logic signed [7:0] v, input logic sgn);
    return sgn ? {{(XLEN-8){v[7]}}, v} : {{(XLEN-8){1'b0}}, v};
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic signed [15:0] v, input logic sgn);
    return sgn ? {{(XLEN-16){v[15]}}, v} : {{(XLEN-16){1'b0}}, v};
  endfunction

  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

  logic [XLEN-1:0] ld_shifted;

  always_comb begin
    st_wdata = st_data;
    st_wmask = MASK_W;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_wdata = {4{st_data[7:0]}};
        st_wmask = MASK_B << st_off;
      end
      F3_H, F3_HU: begin
        st_wdata = {2{st_data[15:0]}};
        st_wmask = st_off[1] ? (MASK_H << 2) : MASK_H;
      end
      default: ;
    endcase
    st_fault = access_fault(st_funct3, st_off);
  end

  // Loads: bring the addressed byte/half down to lane 0, then extend.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = ext8(ld_shifted[7:0], 1'b1);
      F3_BU:   ld_data = ext8(ld_shifted[7:0], 1'b0);
      F3_H:    ld_data = ext16(ld_shifted[15:0], 1'b1);
      F3_HU:   ld_data = ext16(ld_shifted[15:0], 1'b0);
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: captures an execute result, runs the req/gnt/rvalid handshake with
// data memory and produces one registered writeback result per instruction.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [4:0]      i_rd,
  input  logic            i_reg_write,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_wmask,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_wb_valid,
  output logic [XLEN-1:0] o_wb_data,
  output logic [4:0]      o_wb_rd,
  output logic            o_wb_reg_write,
  output logic            o_fault
);

  state_t          state_q, state_d;
  logic            accept, is_mem, st_fault, mem_go, fault_go;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [3:0]      st_wmask;
  logic [2:0]      funct3_p1;
  logic [1:0]      off_p1;
  logic [4:0]      rd_p1;
  logic            regw_p1;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_funct3 (i_funct3),
    .st_off    (i_addr[1:0]),
    .st_data   (i_store_data),
    .st_wdata  (st_wdata),
    .st_wmask  (st_wmask),
    .st_fault  (st_fault),
    .ld_funct3 (funct3_p1),
    .ld_off    (off_p1),
    .ld_rdata  (i_dmem_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_go)     state_d = ST_REQ;
      ST_REQ:  if (i_dmem_gnt) state_d = o_dmem_we ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (i_dmem_rvalid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready  = i_rst_n && (state_q == ST_IDLE);
    accept   = i_valid && o_ready;
    is_mem   = i_mem_read || i_mem_write;
    fault_go = accept && is_mem && st_fault;
    mem_go   = accept && is_mem && !st_fault;
  end

  // Stage p1: per-instruction context needed when the load data returns.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      funct3_p1 <= i_funct3;
      off_p1    <= i_addr[1:0];
      rd_p1     <= i_rd;
      regw_p1   <= i_reg_write;
    end
  end

  // Memory request registers; address/data stay put after gnt, only req drops.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_wmask <= '0;
    end else if (mem_go) begin
      o_dmem_req   <= 1'b1;
      o_dmem_we    <= i_mem_write;
      o_dmem_addr  <= {i_addr[XLEN-1:2], 2'b00};
      o_dmem_wdata <= i_mem_write ? st_wdata : '0;
      o_dmem_wmask <= i_mem_write ? st_wmask : 4'b0000;
    end else if (state_q == ST_REQ && i_dmem_gnt) begin
      o_dmem_req   <= 1'b0;
    end
  end

  // Writeback registers: everything holds except the valid pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_wb_valid     <= 1'b0;
      o_wb_data      <= '0;
      o_wb_rd        <= '0;
      o_wb_reg_write <= 1'b0;
      o_fault        <= 1'b0;
    end else begin
      o_wb_valid <= 1'b0;
      if (accept && !is_mem) begin
        o_wb_valid     <= 1'b1;
        o_wb_data      <= i_addr;
        o_wb_rd        <= i_rd;
        o_wb_reg_write <= i_reg_write;
        o_fault        <= 1'b0;
      end else if (fault_go) begin
        o_wb_valid     <= 1'b1;
        o_wb_data      <= '0;
        o_wb_rd        <= i_rd;
        o_wb_reg_write <= 1'b0;
        o_fault        <= 1'b1;
      end else if (state_q == ST_REQ && i_dmem_gnt && o_dmem_we) begin
        o_wb_valid     <= 1'b1;
        o_wb_data      <= '0;
        o_wb_rd        <= rd_p1;
        o_wb_reg_write <= 1'b0;
        o_fault        <= 1'b0;
      end else if (state_q == ST_WAIT && i_dmem_rvalid) begin
        o_wb_valid     <= 1'b1;
        o_wb_data      <= ld_data;
        o_wb_rd        <= rd_p1;
        o_wb_reg_write <= regw_p1;
        o_fault        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: directed scenarios plus random ops against a
// behavioural model of the load/store rules and the handshake timing.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_mem_read, i_mem_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_store_data;
  logic [4:0]  i_rd;
  logic        i_reg_write;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_wmask;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_wb_valid;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic        o_wb_reg_write, o_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  mem_stage #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_store_data(i_store_data), .i_rd(i_rd), .i_reg_write(i_reg_write),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_wmask(o_dmem_wmask), .i_dmem_gnt(i_dmem_gnt),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata), .o_wb_valid(o_wb_valid),
    .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd), .o_wb_reg_write(o_wb_reg_write), .o_fault(o_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // ---- reference model ----
  function automatic int unsigned size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_fault(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd_word);
    logic [31:0] w;
    logic [31:0] v;
    w = rd_word / (32'd1 << (8 * (a % 4)));
    case (f3)
      3'd0: begin v = w % 256;   return (v >= 128)   ? v - 32'd256   : v; end
      3'd4: return w % 256;
      3'd1: begin v = w % 65536; return (v >= 32768) ? v - 32'd65536 : v; end
      3'd5: return w % 65536;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_of(f3))
      1: return (d % 256) * 32'h0101_0101;
      2: return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_wmask(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    n = size_of(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  // Issue one instruction from IDLE and play the memory side; checks every cycle.
  task automatic run_op(input bit rd_op, input bit wr_op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                        input bit regw, input logic [31:0] rword, input int gnt_dly,
                        input int rv_dly, input bit rv_noise);
    bit mem, flt;
    mem = rd_op || wr_op;
    flt = mem && model_fault(f3, a);
    chk("ready_idle", 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_mem_read = rd_op; i_mem_write = wr_op; i_funct3 = f3;
    i_addr = a; i_store_data = sd; i_rd = rd; i_reg_write = regw;
    tick();
    i_valid = 1'b0;
    if (!mem || flt) begin
      chk("imm_wb_valid", 32'(o_wb_valid), 32'd1);
      chk("imm_wb_data", o_wb_data, flt ? 32'd0 : a);
      chk("imm_wb_rd", 32'(o_wb_rd), 32'(rd));
      chk("imm_wb_regw", 32'(o_wb_reg_write), flt ? 32'd0 : 32'(regw));
      chk("imm_fault", 32'(o_fault), 32'(flt));
      chk("imm_no_req", 32'(o_dmem_req), 32'd0);
      return;
    end
    for (int k = 0; k <= gnt_dly; k++) begin
      chk("req_high", 32'(o_dmem_req), 32'd1);
      chk("req_we", 32'(o_dmem_we), 32'(wr_op));
      chk("req_addr", o_dmem_addr, a & 32'hFFFF_FFFC);
      chk("req_wdata", o_dmem_wdata, wr_op ? model_wdata(f3, sd) : 32'd0);
      chk("req_wmask", 32'(o_dmem_wmask), wr_op ? 32'(model_wmask(f3, a)) : 32'd0);
      chk("req_busy", 32'(o_ready), 32'd0);
      chk("req_no_wb", 32'(o_wb_valid), 32'd0);
      i_dmem_gnt = (k == gnt_dly);
      i_dmem_rvalid = rv_noise;
      i_dmem_rdata = $urandom;
      tick();
      i_dmem_gnt = 1'b0;
      i_dmem_rvalid = 1'b0;
    end
    chk("gnt_req_drop", 32'(o_dmem_req), 32'd0);
    if (wr_op) begin
      chk("st_wb_valid", 32'(o_wb_valid), 32'd1);
      chk("st_wb_regw", 32'(o_wb_reg_write), 32'd0);
      chk("st_fault", 32'(o_fault), 32'd0);
      return;
    end
    for (int k = 0; k < rv_dly; k++) begin
      chk("wait_no_wb", 32'(o_wb_valid), 32'd0);
      chk("wait_busy", 32'(o_ready), 32'd0);
      tick();
    end
    chk("wait_no_wb", 32'(o_wb_valid), 32'd0);
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata = rword;
    tick();
    i_dmem_rvalid = 1'b0;
    chk("ld_wb_valid", 32'(o_wb_valid), 32'd1);
    chk("ld_wb_data", o_wb_data, model_load(f3, a, rword));
    chk("ld_wb_rd", 32'(o_wb_rd), 32'(rd));
    chk("ld_wb_regw", 32'(o_wb_reg_write), 32'(regw));
    chk("ld_fault", 32'(o_fault), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    i_rst_n = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_funct3 = 3'd0; i_addr = '0; i_store_data = '0; i_rd = '0; i_reg_write = 1'b0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
    tick(); tick();
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_we", 32'(o_dmem_we), 32'd0);
    chk("rst_addr", o_dmem_addr, 32'd0);
    chk("rst_wdata", o_dmem_wdata, 32'd0);
    chk("rst_wmask", 32'(o_dmem_wmask), 32'd0);
    chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
    chk("rst_wb_data", o_wb_data, 32'd0);
    chk("rst_wb_rd", 32'(o_wb_rd), 32'd0);
    chk("rst_wb_regw", 32'(o_wb_reg_write), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    i_rst_n = 1'b1;
    #1;

    // Back-to-back non-memory ops
    i_valid = 1'b1; i_addr = 32'h0000_1234; i_rd = 5'd5; i_reg_write = 1'b1;
    chk("b2b_ready0", 32'(o_ready), 32'd1);
    tick();
    chk("b2b_wb0_valid", 32'(o_wb_valid), 32'd1);
    chk("b2b_wb0_data", o_wb_data, 32'h0000_1234);
    chk("b2b_wb0_rd", 32'(o_wb_rd), 32'd5);
    chk("b2b_ready1", 32'(o_ready), 32'd1);
    i_addr = 32'h0000_0055; i_rd = 5'd6;
    tick();
    i_valid = 1'b0;
    chk("b2b_wb1_valid", 32'(o_wb_valid), 32'd1);
    chk("b2b_wb1_data", o_wb_data, 32'h0000_0055);
    chk("b2b_wb1_rd", 32'(o_wb_rd), 32'd6);
    tick();
    chk("wb_pulse_end", 32'(o_wb_valid), 32'd0);
    chk("wb_data_hold", o_wb_data, 32'h0000_0055);

    // Directed memory cases
    run_op(0, 1, 3'd0, 32'h103, 32'h0000_00AB, 5'd1, 1, 32'd0, 2, 0, 0);
    run_op(1, 0, 3'd0, 32'h102, 32'd0, 5'd7, 1, 32'h0080_0000, 0, 3, 1);
    run_op(1, 0, 3'd4, 32'h102, 32'd0, 5'd7, 1, 32'h0080_0000, 1, 3, 1);
    run_op(1, 0, 3'd1, 32'h002, 32'd0, 5'd8, 1, 32'h8001_0000, 0, 1, 0);
    run_op(1, 0, 3'd5, 32'h002, 32'd0, 5'd8, 1, 32'h8001_0000, 0, 0, 0);
    run_op(1, 0, 3'd2, 32'h202, 32'd0, 5'd9, 1, 32'd0, 0, 0, 0);
    run_op(1, 0, 3'd3, 32'h200, 32'd0, 5'd9, 1, 32'd0, 0, 0, 0);
    run_op(0, 1, 3'd1, 32'h302, 32'h1234_BEEF, 5'd2, 1, 32'd0, 0, 0, 0);
    run_op(0, 1, 3'd2, 32'h300, 32'hCAFE_F00D, 5'd2, 1, 32'd0, 1, 0, 0);

    // Reset during REQ abandons the request at that edge
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_funct3 = 3'd2;
    i_addr = 32'h40; i_rd = 5'd3;
    tick();
    i_valid = 1'b0;
    chk("rreq_req", 32'(o_dmem_req), 32'd1);
    i_rst_n = 1'b0;
    tick();
    chk("rreq_req_drop", 32'(o_dmem_req), 32'd0);
    i_rst_n = 1'b1;
    #1;

    // Reset during WAIT; a late rvalid must not produce a writeback
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_dmem_gnt = 1'b1;
    tick();
    i_dmem_gnt = 1'b0;
    chk("rwait_busy", 32'(o_ready), 32'd0);
    i_rst_n = 1'b0;
    tick();
    chk("rwait_req", 32'(o_dmem_req), 32'd0);
    chk("rwait_wb_valid", 32'(o_wb_valid), 32'd0);
    chk("rwait_ready_in_rst", 32'(o_ready), 32'd0);
    i_rst_n = 1'b1;
    #1;
    chk("rwait_ready_after", 32'(o_ready), 32'd1);
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF;
    tick();
    i_dmem_rvalid = 1'b0;
    chk("late_rvalid_ignored", 32'(o_wb_valid), 32'd0);
    chk("late_rvalid_ready", 32'(o_ready), 32'd1);

    // Random mix
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [2:0] f3;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
           : (kind == 1) ? 3'($urandom_range(0, 2))
           : 3'($urandom_range(0, 5));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(f3)) - 32'd1);
      run_op(kind == 0, kind == 1, f3, a, $urandom, 5'($urandom), 1'($urandom),
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        held = o_wb_data;
        tick();
        chk("rnd_idle_no_wb", 32'(o_wb_valid), 32'd0);
        chk("rnd_idle_hold", o_wb_data, held);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
